ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port (Avalon-MM + stream prefetch) arbiter onto one RAM read/write port
// Optional starvation fairness for the stream port: define RAM_ARB_FAIRNESS_EN.
module ram_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int NSYM     = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [NSYM-1:0]   avs_byteenable,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              str_req,
  input  logic [ADDR_W-1:0] str_addr,
  output logic              str_gnt,
  output logic [DATA_W-1:0] str_rdata,
  output logic              str_rvalid,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [NSYM-1:0]   ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic w_mm_req;
  logic w_override;
  logic w_str_gnt;
  logic w_mm_gnt;
  logic w_mm_wr;
  logic w_mm_rd;
  logic w_rd;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_din;
  logic [NSYM-1:0]   r_we;
  logic [DATA_W-1:0] r_avs_rdata;
  logic [DATA_W-1:0] r_str_rdata;
  logic [1:0]        r_tag_v;
  logic [1:0]        r_tag_own;

  // Grants are forced low in reset so nothing is issued while the pipe is held clear.
  assign w_mm_req  = avs_read | avs_write;
  assign w_str_gnt = reset_n & str_req & (w_override | ~w_mm_req);
  assign w_mm_gnt  = reset_n & w_mm_req & ~w_str_gnt;
  assign w_mm_wr   = w_mm_gnt & avs_write;
  assign w_mm_rd   = w_mm_gnt & avs_read & ~avs_write;
  assign w_rd      = w_mm_rd | w_str_gnt;

  assign avs_waitrequest = ~reset_n | (w_mm_req & ~w_mm_gnt);
  assign str_gnt         = w_str_gnt;

`ifdef RAM_ARB_FAIRNESS_EN
  logic [3:0] r_starve;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (str_req && !w_str_gnt) begin
      if (r_starve != LP_MAX_WAIT) r_starve <= r_starve + 4'd1;
    end else begin
      r_starve <= '0;
    end
  end

  assign w_override = (r_starve == LP_MAX_WAIT);
`else
  logic w_unused_max_wait;
  assign w_unused_max_wait = |LP_MAX_WAIT;
  assign w_override        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_addr <= '0;
      r_din     <= '0;
      r_we      <= '0;
      r_rd_addr <= '0;
    end else begin
      r_we <= w_mm_wr ? avs_byteenable : '0;
      if (w_mm_wr) begin
        r_wr_addr <= avs_address;
        r_din     <= avs_writedata;
      end
      if (w_rd) r_rd_addr <= w_mm_rd ? avs_address : str_addr;
    end
  end

  // Stage 0 marks the cycle ram_q is valid; stage 1 is the strobe cycle. Owner 1 = stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_v     <= '0;
      r_tag_own   <= '0;
      r_avs_rdata <= '0;
      r_str_rdata <= '0;
    end else begin
      r_tag_v   <= {r_tag_v[0], w_rd};
      r_tag_own <= {r_tag_own[0], w_str_gnt};
      if (r_tag_v[0]) begin
        if (r_tag_own[0]) r_str_rdata <= ram_q;
        else              r_avs_rdata <= ram_q;
      end
    end
  end

  assign ram_rd_addr       = r_rd_addr;
  assign ram_wr_addr       = r_wr_addr;
  assign ram_din           = r_din;
  assign ram_we            = r_we;
  assign avs_readdata      = r_avs_rdata;
  assign str_rdata         = r_str_rdata;
  assign avs_readdatavalid = r_tag_v[1] & ~r_tag_own[1];
  assign str_rvalid        = r_tag_v[1] & r_tag_own[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter with a byte-lane RAM model
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        str_req;
  logic [15:0] str_addr;
  logic        str_gnt;
  logic [31:0] str_rdata;
  logic        str_rvalid;
  logic [15:0] ram_rd_addr;
  logic [15:0] ram_wr_addr;
  logic [31:0] ram_din;
  logic [3:0]  ram_we;
  logic [31:0] ram_q;

  logic [31:0] mem [0:65535];

  int n_chk  = 0;
  int n_pass = 0;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .NSYM(4), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .str_req(str_req), .str_addr(str_addr), .str_gnt(str_gnt),
    .str_rdata(str_rdata), .str_rvalid(str_rvalid),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_wr_addr][8*b +: 8] <= ram_din[8*b +: 8];
  end

  assign ram_q = mem[ram_rd_addr];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    avs_read = 0; avs_write = 0; avs_address = '0; avs_byteenable = '0;
    avs_writedata = '0; str_req = 0; str_addr = '0;
  endtask

  logic [11:0] gnt_pat;
  logic [11:0] wait_pat;
  logic        seen_strobe;
  logic [31:0] alt_exp [0:5];

  initial begin
    reset_n = 0;
    idle_inputs();
    avs_read = 1; str_req = 1;
    #1;
    chk("rst_waitrequest", avs_waitrequest, 1);
    chk("rst_str_gnt", str_gnt, 0);
    tick(); tick();
    chk("rst_outputs", {ram_we, avs_readdatavalid, str_rvalid}, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    idle_inputs();
    reset_n = 1;
    tick();

    // MM write then read of 0x0010
    avs_write = 1; avs_address = 16'h0010; avs_writedata = 32'hDEADBEEF; avs_byteenable = 4'hF;
    #1 chk("wr_waitrequest", avs_waitrequest, 0);
    tick();
    chk("wr_ram_we", ram_we, 4'hF);
    chk("wr_ram_wr_addr", ram_wr_addr, 16'h0010);
    chk("wr_ram_din", ram_din, 32'hDEADBEEF);
    idle_inputs();
    tick();
    chk("wr_we_cleared", ram_we, 0);
    avs_read = 1; avs_address = 16'h0010;
    #1 chk("rd_waitrequest", avs_waitrequest, 0);
    tick();
    idle_inputs();
    chk("rd_ram_rd_addr", ram_rd_addr, 16'h0010);
    chk("rd_valid_n1", avs_readdatavalid, 0);
    tick();
    chk("rd_valid_n2", avs_readdatavalid, 1);
    chk("rd_data", avs_readdata, 32'hDEADBEEF);
    tick();
    chk("rd_valid_pulse", avs_readdatavalid, 0);
    chk("rd_data_hold", avs_readdata, 32'hDEADBEEF);

    // Partial byte-lane write to address 5
    avs_write = 1; avs_address = 16'd5; avs_writedata = 32'hAABBCCDD; avs_byteenable = 4'hF;
    tick();
    avs_writedata = 32'h11223344; avs_byteenable = 4'h3;
    tick();
    chk("be_ram_we", ram_we, 4'h3);
    idle_inputs();
    tick();
    avs_read = 1; avs_address = 16'd5;
    tick();
    idle_inputs();
    tick();
    chk("be_valid", avs_readdatavalid, 1);
    chk("be_data", avs_readdata, 32'hAABB3344);
    tick();

    // MM read and stream request held together
    avs_read = 1; avs_address = 16'd0; str_req = 1; str_addr = 16'd3;
    for (int i = 0; i < 12; i++) begin
      gnt_pat[i]  = str_gnt;
      wait_pat[i] = avs_waitrequest;
      tick();
    end
    idle_inputs();
`ifdef RAM_ARB_FAIRNESS_EN
    chk("starve_gnt_pattern", gnt_pat, 12'h210);
    chk("starve_wait_pattern", wait_pat, 12'h210);
`else
    chk("strict_gnt_pattern", gnt_pat, 12'h000);
    chk("strict_wait_pattern", wait_pat, 12'h000);
`endif
    tick(); tick(); tick();

    // Alternating MM / stream reads of addresses 1..6, back to back
    alt_exp[0] = 32'h1000_0001; alt_exp[1] = 32'h1000_0002; alt_exp[2] = 32'h1000_0003;
    alt_exp[3] = 32'h1000_0004; alt_exp[4] = 32'hAABB3344; alt_exp[5] = 32'h1000_0006;
    for (int t = 0; t < 8; t++) begin
      idle_inputs();
      if (t < 6) begin
        if (t % 2 == 0) begin
          avs_read = 1; avs_address = 16'(t + 1);
        end else begin
          str_req = 1; str_addr = 16'(t + 1);
        end
        #1;
        if (t % 2 == 0) chk($sformatf("alt_mm_gnt%0d", t), avs_waitrequest, 0);
        else            chk($sformatf("alt_str_gnt%0d", t), str_gnt, 1);
      end
      if (t >= 2) begin
        if ((t - 2) % 2 == 0) begin
          chk($sformatf("alt_strobes%0d", t - 2), {avs_readdatavalid, str_rvalid}, 2'b10);
          chk($sformatf("alt_avs_data%0d", t - 2), avs_readdata, alt_exp[t-2]);
        end else begin
          chk($sformatf("alt_strobes%0d", t - 2), {avs_readdatavalid, str_rvalid}, 2'b01);
          chk($sformatf("alt_str_data%0d", t - 2), str_rdata, alt_exp[t-2]);
        end
      end
      tick();
    end
    chk("alt_idle_strobes", {avs_readdatavalid, str_rvalid}, 0);

    // Reset with two reads in flight
    avs_read = 1; avs_address = 16'd1;
    tick();
    idle_inputs();
    str_req = 1; str_addr = 16'd2;
    tick();
    idle_inputs();
    reset_n = 0;
    #1;
    chk("midrst_strobes", {avs_readdatavalid, str_rvalid}, 0);
    chk("midrst_ram_ctl", {ram_we, ram_rd_addr, ram_wr_addr}, 0);
    chk("midrst_ram_din", ram_din, 0);
    chk("midrst_avs_rdata", avs_readdata, 0);
    chk("midrst_str_rdata", str_rdata, 0);
    tick();
    reset_n = 1;
    seen_strobe = 0;
    for (int i = 0; i < 4; i++) begin
      seen_strobe = seen_strobe | avs_readdatavalid | str_rvalid;
      tick();
    end
    chk("postrst_no_strobe", seen_strobe, 0);

    // Simultaneous read+write is a write only
    avs_read = 1; avs_write = 1; avs_address = 16'd7; avs_writedata = 32'h0000_0077; avs_byteenable = 4'hF;
    #1 chk("rw_waitrequest", avs_waitrequest, 0);
    tick();
    idle_inputs();
    chk("rw_ram_we", ram_we, 4'hF);
    chk("rw_ram_wr_addr", ram_wr_addr, 16'd7);
    chk("rw_no_rd_addr", ram_rd_addr, 0);
    seen_strobe = 0;
    for (int i = 0; i < 4; i++) begin
      seen_strobe = seen_strobe | avs_readdatavalid | str_rvalid;
      tick();
    end
    chk("rw_no_readdatavalid", seen_strobe, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
